// File: rtl/ysyx22041405_wbu.sv
// rtl/ysyx22041405_wbu.sv - writeback unit: EXU/LSU arbitration, load formatting, regfile write, busy scoreboard
module ysyx22041405_wbu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic             exu_wen,
  input  logic [4:0]       exu_rd,
  input  logic [WIDTH-1:0] exu_result,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [1:0]       lsu_size,
  input  logic             lsu_unsigned,
  input  logic [2:0]       lsu_addr_lo,
  input  logic [WIDTH-1:0] lsu_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic             busy1,
  output logic             busy2,
  output logic             commit,
  output logic [63:0]      retire_cnt
);

  logic             r_rr_lsu;
  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic [WIDTH-1:0] r_rf_wdata;
  logic             r_commit;
  logic [63:0]      r_retire_cnt;
  logic [31:0]      r_busy;

  logic             w_both;
  logic             w_exu_grant;
  logic             w_lsu_grant;
  logic             w_accept;
  logic [4:0]       w_rd;
  logic             w_we;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_wdata;
  logic [31:0]      w_busy_nxt;

  // Readies are held low while reset is asserted so nothing handshakes into a clearing unit.
  assign w_both      = exu_valid & lsu_valid;
  assign w_lsu_grant = rst & lsu_valid & (~exu_valid | r_rr_lsu);
  assign w_exu_grant = rst & exu_valid & (~lsu_valid | ~r_rr_lsu);
  assign w_accept    = w_lsu_grant | w_exu_grant;

  assign exu_ready = w_exu_grant;
  assign lsu_ready = w_lsu_grant;

  generate
    if (WIDTH == 64) begin : g_load64
      logic [7:0]  w_b;
      logic [15:0] w_h;
      logic [31:0] w_w;
      assign w_b = lsu_rdata[{lsu_addr_lo, 3'b000} +: 8];
      assign w_h = lsu_rdata[{lsu_addr_lo[2:1], 4'b0000} +: 16];
      assign w_w = lsu_rdata[{lsu_addr_lo[2], 5'b00000} +: 32];
      always_comb begin
        w_load = lsu_rdata;
        case (lsu_size)
          2'd0:    w_load = {{56{w_b[7] & ~lsu_unsigned}}, w_b};
          2'd1:    w_load = {{48{w_h[15] & ~lsu_unsigned}}, w_h};
          2'd2:    w_load = {{32{w_w[31] & ~lsu_unsigned}}, w_w};
          default: w_load = lsu_rdata;
        endcase
      end
    end else begin : g_load32
      logic [7:0]  w_b;
      logic [15:0] w_h;
      logic        w_unused_lane;
      assign w_unused_lane = lsu_addr_lo[2];
      assign w_b = lsu_rdata[{lsu_addr_lo[1:0], 3'b000} +: 8];
      assign w_h = lsu_rdata[{lsu_addr_lo[1], 4'b0000} +: 16];
      // A dword request on a 32-bit core degrades to the full word.
      always_comb begin
        w_load = lsu_rdata;
        case (lsu_size)
          2'd0:    w_load = {{24{w_b[7] & ~lsu_unsigned}}, w_b};
          2'd1:    w_load = {{16{w_h[15] & ~lsu_unsigned}}, w_h};
          default: w_load = lsu_rdata;
        endcase
      end
    end
  endgenerate

  assign w_rd    = w_lsu_grant ? lsu_rd : exu_rd;
  assign w_we    = (w_rd != 5'd0) & (w_lsu_grant | exu_wen);
  assign w_wdata = w_lsu_grant ? w_load : exu_result;

  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_we) begin
      w_busy_nxt[r_rf_waddr] = 1'b0;
    end
    // Set after clear: a re-issue of the register being written must stay busy.
    if (issue_valid && (issue_rd != 5'd0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_lsu     <= 1'b1;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= 5'd0;
      r_rf_wdata   <= '0;
      r_commit     <= 1'b0;
      r_retire_cnt <= 64'd0;
      r_busy       <= 32'd0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_commit <= w_accept;
      if (w_both) begin
        r_rr_lsu <= ~r_rr_lsu;
      end
      if (w_accept) begin
        r_rf_we      <= w_we;
        r_rf_waddr   <= w_rd;
        r_rf_wdata   <= w_wdata;
        r_retire_cnt <= r_retire_cnt + 64'd1;
      end else begin
        r_rf_we <= 1'b0;
      end
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign commit     = r_commit;
  assign retire_cnt = r_retire_cnt;
  assign busy1      = r_busy[raddr1];
  assign busy2      = r_busy[raddr2];

endmodule
